// File: rtl/lcd_bus_rx.sv
// lcd_bus_rx: receiver for an 8-bit HD44780-style LCD write bus.
// It latches each write transfer on the falling edge of en and decodes the
// command subset the LCD writer uses. It keeps a 2x16 shadow of the display
// characters, which is read through a registered port.
// Optional feature macro: LCD_RX_STATS_EN adds the cmd_count/dat_count
// saturating transfer counters.

module lcd_bus_rx #(
   parameter int MIN_EN_HIGH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] lcd_dat,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_en,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic       wr_valid,
   output logic       wr_rs,
   output logic [7:0] wr_data,
   output logic [6:0] cursor,
   output logic       disp_on,
   output logic       clear_busy,
   output logic       err_overrun
`ifdef LCD_RX_STATS_EN
   ,
   output logic [15:0] cmd_count,
   output logic [15:0] dat_count
`endif
);

   localparam int CW = (MIN_EN_HIGH < 2) ? 1 : $clog2(MIN_EN_HIGH + 1);

   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [1:0]      en_s, rs_s, rw_s;
   logic [1:0][7:0] dat_s;
   logic            en_q;
   logic [CW-1:0]   hi_cnt;
   logic            fall, accept;
   logic            acc_q, acc_rs;
   logic [7:0]      acc_dat;
   logic            commit, overrun;
   logic            id_q, id_d, disp_d;
   logic [6:0]      cur_d;
   logic            clr_start, shadow_we, sweep_we;
   logic [4:0]      sw_idx;
   logic [7:0]      shadow [32];

   // DDRAM address step with the two-line wrap points; the hole 0x28-0x3F counts through
   function automatic logic [6:0] step(input logic [6:0] c, input logic inc);
      logic [6:0] r;
      if (inc) begin
         case (c)
            7'h27:   r = 7'h40;
            7'h67:   r = 7'h00;
            default: r = c + 7'd1;   // 0x7F wraps to 0x00 naturally
         endcase
      end else begin
         case (c)
            7'h00:   r = 7'h67;
            7'h40:   r = 7'h27;
            default: r = c - 7'd1;
         endcase
      end
      return r;
   endfunction

   // 2-flop synchronizers for all bus pins, plus the previous synchronized en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_s  <= '0;
         rs_s  <= '0;
         rw_s  <= '0;
         dat_s <= '0;
         en_q  <= 1'b0;
      end else begin
         en_s  <= {en_s[0], lcd_en};
         rs_s  <= {rs_s[0], lcd_rs};
         rw_s  <= {rw_s[0], lcd_rw};
         dat_s <= {dat_s[0], lcd_dat};
         en_q  <= en_s[1];
      end
   end

   // Saturating count of synchronized en high cycles, cleared while en is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           hi_cnt <= '0;
      else if (!en_s[1])                    hi_cnt <= '0;
      else if (hi_cnt < CW'(MIN_EN_HIGH))   hi_cnt <= hi_cnt + 1'b1;
   end

   assign fall   = en_q & ~en_s[1];
   assign accept = fall & (hi_cnt >= CW'(MIN_EN_HIGH)) & ~rw_s[1];

   // Capture the accepted transfer; it commits on the following edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= 1'b0;
         acc_rs  <= 1'b0;
         acc_dat <= '0;
      end else begin
         acc_q <= accept;
         if (accept) begin
            acc_rs  <= rs_s[1];
            acc_dat <= dat_s[1];
         end
      end
   end

   // Transfers landing during a clear sweep are dropped and flagged
   assign commit  = acc_q & (state_q == S_IDLE);
   assign overrun = acc_q & (state_q == S_CLEAR);

   // Command/data decode into next cursor, I/D, display-on and clear start
   always_comb begin
      cur_d     = cursor;
      id_d      = id_q;
      disp_d    = disp_on;
      clr_start = 1'b0;
      shadow_we = 1'b0;
      if (commit) begin
         if (acc_rs) begin
            shadow_we = (cursor[5:4] == 2'b00);
            cur_d     = step(cursor, id_q);
         end else if (acc_dat[7]) begin
            cur_d = acc_dat[6:0];
         end else if (acc_dat[7:3] == 5'b00001) begin
            disp_d = acc_dat[2];
         end else if (acc_dat[7:2] == 6'b000001) begin
            id_d = acc_dat[1];
         end else if (acc_dat[7:1] == 7'b0000001) begin
            cur_d = '0;
         end else if (acc_dat == 8'h01) begin
            clr_start = 1'b1;
            cur_d     = '0;
            id_d      = 1'b1;
         end
      end
   end

   // Architectural state and the transfer report outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_valid    <= 1'b0;
         wr_rs       <= 1'b0;
         wr_data     <= '0;
         cursor      <= '0;
         id_q        <= 1'b1;
         disp_on     <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         wr_valid <= commit;
         if (commit) begin
            wr_rs   <= acc_rs;
            wr_data <= acc_dat;
         end
         cursor      <= cur_d;
         id_q        <= id_d;
         disp_on     <= disp_d;
         err_overrun <= err_overrun | overrun;
      end
   end

   // Sweep FSM state register; reset lands in CLEAR so the shadow gets filled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_CLEAR;
      else        state_q <= state_d;
   end

   // Sweep FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (clr_start) state_d = S_CLEAR;
         S_CLEAR: if (sw_idx == 5'd31) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Sweep FSM outputs
   always_comb begin
      clear_busy = (state_q == S_CLEAR);
      sweep_we   = (state_q == S_CLEAR);
   end

   // Sweep index; wraps back to 0 after 31
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         sw_idx <= '0;
      else if (clr_start) sw_idx <= '0;
      else if (sweep_we)  sw_idx <= sw_idx + 5'd1;
   end

   // Shadow RAM write port (not reset; the sweep fills it)
   always_ff @(posedge clk) begin
      if (sweep_we)       shadow[sw_idx] <= 8'h20;
      else if (shadow_we) shadow[{cursor[6], cursor[3:0]}] <= acc_dat;
   end

   // Registered read port; a same-cycle write is seen on the next read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_char <= '0;
      else        rd_char <= shadow[rd_addr];
   end

`ifdef LCD_RX_STATS_EN
   // Saturating counters of committed command and data transfers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_count <= '0;
         dat_count <= '0;
      end else if (commit) begin
         if (!acc_rs && cmd_count != 16'hFFFF) cmd_count <= cmd_count + 16'd1;
         if (acc_rs  && dat_count != 16'hFFFF) dat_count <= dat_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lcd_bus_rx.sv
// tb_lcd_bus_rx: directed and random bus transfers against a behavioural
// model of the display shadow, cursor and flags.

module tb_lcd_bus_rx;

   localparam int MIN_EN_HIGH = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] lcd_dat = '0;
   logic       lcd_rs = 1'b0;
   logic       lcd_rw = 1'b0;
   logic       lcd_en = 1'b0;
   logic [4:0] rd_addr = '0;
   logic [7:0] rd_char;
   logic       wr_valid, wr_rs;
   logic [7:0] wr_data;
   logic [6:0] cursor;
   logic       disp_on, clear_busy, err_overrun;
`ifdef LCD_RX_STATS_EN
   logic [15:0] cmd_count, dat_count;
`endif

   lcd_bus_rx #(.MIN_EN_HIGH(MIN_EN_HIGH)) dut (
      .clk(clk), .rst_n(rst_n), .lcd_dat(lcd_dat), .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw), .lcd_en(lcd_en), .rd_addr(rd_addr), .rd_char(rd_char),
      .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data), .cursor(cursor),
      .disp_on(disp_on), .clear_busy(clear_busy), .err_overrun(err_overrun)
`ifdef LCD_RX_STATS_EN
      , .cmd_count(cmd_count), .dat_count(dat_count)
`endif
   );

   always #10 clk = ~clk;

   int cyc = 0;
   int pulses = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (wr_valid === 1'b1) pulses <= pulses + 1;

   int checks = 0;
   int errors = 0;

   // model state
   logic [7:0] m_mem [32];
   logic [6:0] m_cur;
   logic       m_id, m_disp, m_err;
   int         m_clr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_cur  = 7'h00;
      m_id   = 1'b1;
      m_disp = 1'b0;
      m_err  = 1'b0;
      m_clr  = -1000;
   endtask

   // Visible lines live at 0x00-0x27 and 0x40-0x67; stepping past an end jumps to the other line
   function automatic logic [6:0] m_next(input logic [6:0] c, input logic inc);
      int v;
      if (inc) begin
         if (c == 7'h27) v = 'h40;
         else if (c == 7'h67) v = 0;
         else v = (int'(c) + 1) % 128;
      end else begin
         if (c == 7'h00) v = 'h67;
         else if (c == 7'h40) v = 'h27;
         else v = int'(c) - 1;
      end
      return 7'(v);
   endfunction

   // Apply one bus transfer that commits at cycle t; acc tells whether it is reported
   task automatic model_apply(input logic rs, input logic [7:0] d, input logic rw,
                              input int hi, input int t, output logic acc);
      acc = 1'b0;
      if (hi < MIN_EN_HIGH || rw) return;
      if (t > m_clr && t <= m_clr + 32) begin
         m_err = 1'b1;
         return;
      end
      acc = 1'b1;
      if (rs) begin
         if (m_cur[5:4] == 2'b00) m_mem[{m_cur[6], m_cur[3:0]}] = d;
         m_cur = m_next(m_cur, m_id);
      end else if (d == 8'h01) begin
         for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
         m_cur = 7'h00;
         m_id  = 1'b1;
         m_clr = t;
      end else if (d == 8'h02 || d == 8'h03) m_cur = 7'h00;
      else if (d >= 8'h04 && d <= 8'h07) m_id = d[1];
      else if (d >= 8'h08 && d <= 8'h0F) m_disp = d[2];
      else if (d >= 8'h80) m_cur = d[6:0];
   endtask

   // One transfer: en high for hi clk samples, then low; pulse checked at the 4th edge after the drop
   task automatic send(input logic rs, input logic [7:0] d, input logic rw, input int hi, input int lo);
      logic want;
      int   t;
      @(posedge clk);
      #1 lcd_rs = rs; lcd_dat = d; lcd_rw = rw; lcd_en = 1'b1;
      repeat (hi) @(posedge clk);
      #1 lcd_en = 1'b0;
      t = cyc + 4;
      model_apply(rs, d, rw, hi, t, want);
      repeat (4) @(negedge clk);
      chk("wv_early", 32'(wr_valid), 32'(0));
      @(negedge clk);
      chk("wv_pulse", 32'(wr_valid), 32'(want));
      if (want) begin
         chk("wr_rs", 32'(wr_rs), 32'(rs));
         chk("wr_data", 32'(wr_data), 32'(d));
      end
      chk("cursor", 32'(cursor), 32'(m_cur));
      @(negedge clk);
      chk("wv_end", 32'(wr_valid), 32'(0));
      repeat (lo) @(posedge clk);
   endtask

   task automatic check_mem();
      for (int i = 0; i < 32; i++) begin
         @(posedge clk);
         #1 rd_addr = 5'(i);
         @(posedge clk);
         #1 chk($sformatf("shadow[%0d]", i), 32'(rd_char), 32'(m_mem[i]));
      end
   endtask

   // Call #1 after the edge where rst_n rose
   task automatic count_busy();
      int n = 0;
      repeat (40) begin
         @(negedge clk);
         if (clear_busy === 1'b1) n++;
      end
      chk("clear_len", 32'(n), 32'(32));
   endtask

   initial begin
      int p0;
      logic [7:0] txt [10];
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_valid", 32'(wr_valid), 32'(0));
      chk("rst_wr_rs", 32'(wr_rs), 32'(0));
      chk("rst_wr_data", 32'(wr_data), 32'(0));
      chk("rst_cursor", 32'(cursor), 32'(0));
      chk("rst_disp_on", 32'(disp_on), 32'(0));
      chk("rst_err", 32'(err_overrun), 32'(0));
      chk("rst_rd_char", 32'(rd_char), 32'(0));
      chk("rst_busy", 32'(clear_busy), 32'(1));
      rst_n = 1'b1;
      count_busy();
      check_mem();
      chk("cursor_after_rst", 32'(cursor), 32'(0));

      // init sequence and "Temp:" with slow strobes
      txt = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80, "T", "e", "m", "p", ":"};
      p0 = pulses;
      for (int i = 0; i < 10; i++) send((i >= 5), txt[i], 1'b0, 36, 36);
      chk("temp_pulses", 32'(pulses - p0), 32'(10));
      chk("temp_disp_on", 32'(disp_on), 32'(1));
      chk("temp_cursor", 32'(cursor), 32'(5));
      check_mem();

      // second line, wrap 0x27 -> 0x40, decrement wrap 0x00 -> 0x67
      send(1'b0, 8'hC0, 1'b0, 4, 4);
      send(1'b1, "H", 1'b0, 4, 4);
      chk("line2_cursor", 32'(cursor), 32'(7'h41));
      send(1'b0, 8'hA7, 1'b0, 3, 2);
      send(1'b1, "a", 1'b0, 3, 2);
      chk("wrap_up_cursor", 32'(cursor), 32'(7'h40));
      send(1'b1, "b", 1'b0, 2, 0);
      chk("wrap_up_cursor2", 32'(cursor), 32'(7'h41));
      send(1'b0, 8'h80, 1'b0, 2, 0);
      send(1'b0, 8'h04, 1'b0, 2, 0);
      send(1'b1, "X", 1'b0, 2, 0);
      chk("wrap_dn_cursor", 32'(cursor), 32'(7'h67));
      check_mem();

      // reads (rw=1) and too-short strobes are ignored
      send(1'b1, "Z", 1'b1, 36, 4);
      send(1'b1, "Z", 1'b0, 1, 4);
      chk("ignored_cursor", 32'(cursor), 32'(7'h67));

      // transfer during the clear sweep
      send(1'b0, 8'h01, 1'b0, 4, 0);
      send(1'b1, "Q", 1'b0, 4, 0);
      chk("ovr_err", 32'(err_overrun), 32'(1));
      chk("ovr_busy", 32'(clear_busy), 32'(1));
      repeat (40) @(posedge clk);
      #1 chk("ovr_busy_done", 32'(clear_busy), 32'(0));
      chk("ovr_cursor", 32'(cursor), 32'(0));
      check_mem();

      // random traffic
      for (int k = 0; k < 80; k++) begin
         logic       rs, rw;
         logic [7:0] d;
         rs = 1'($urandom_range(0, 1));
         d  = 8'($urandom_range(0, 255));
         rw = ($urandom_range(0, 7) == 0);
         send(rs, d, rw, int'($urandom_range(1, 5)), int'($urandom_range(0, 12)));
      end
      repeat (40) @(posedge clk);
      #1;
      chk("rnd_cursor", 32'(cursor), 32'(m_cur));
      chk("rnd_disp_on", 32'(disp_on), 32'(m_disp));
      chk("rnd_err", 32'(err_overrun), 32'(m_err));
      chk("rnd_busy", 32'(clear_busy), 32'(0));
      check_mem();

      // reset in the middle of a sweep
      send(1'b0, 8'h0C, 1'b0, 4, 0);
      send(1'b0, 8'h85, 1'b0, 4, 0);
      send(1'b0, 8'h01, 1'b0, 4, 0);
      send(1'b1, "R", 1'b0, 4, 0);
      #3 rst_n = 1'b0;
      #2;
      chk("mid_rst_cursor", 32'(cursor), 32'(0));
      chk("mid_rst_disp", 32'(disp_on), 32'(0));
      chk("mid_rst_err", 32'(err_overrun), 32'(0));
      chk("mid_rst_data", 32'(wr_data), 32'(0));
      chk("mid_rst_busy", 32'(clear_busy), 32'(1));
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      count_busy();
      check_mem();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
